// File: rtl/spi_slave_rx.sv
// spi_slave_rx: mode-0 receive-only SPI slave, MSB first; SPI_SLAVE_RX_ABORT_FLAG_EN adds frame_abort.
module spi_slave_rx #(
  parameter logic IDLE_VAL   = 1'b1,
  parameter int   DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid
`ifdef SPI_SLAVE_RX_ABORT_FLAG_EN
  ,
  output logic                  frame_abort
`endif
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RECEIVE, VALID} state_t;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] sr;
  assign spi_miso = IDLE_VAL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
`ifdef SPI_SLAVE_RX_ABORT_FLAG_EN
      frame_abort <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
`ifdef SPI_SLAVE_RX_ABORT_FLAG_EN
      frame_abort <= spi_cs_n && state == RECEIVE && cnt != '0;
`endif
      if (spi_cs_n) begin
        state <= IDLE;
        cnt   <= '0;
        sr    <= '0;
      end else
        case (state)
          IDLE: begin
            sr    <= {{(DATA_WIDTH-1){1'b0}}, spi_mosi};
            cnt   <= CW'(1);
            state <= RECEIVE;
          end
          RECEIVE:
            if (cnt == CW'(DATA_WIDTH - 1)) begin
              data_out   <= {sr[DATA_WIDTH-2:0], spi_mosi};
              data_valid <= 1'b1;
              cnt        <= '0;
              sr         <= '0;
              state      <= VALID;
            end else begin
              sr  <= {sr[DATA_WIDTH-2:0], spi_mosi};
              cnt <= cnt + CW'(1);
            end
          default: begin
            // gap bit: mosi ignored on this edge
            cnt   <= '0;
            sr    <= '0;
            state <= RECEIVE;
          end
        endcase
    end
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed SPI frames with a queue-based scoreboard on data_valid.
module tb_spi_slave_rx;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n, spi_cs_n, spi_mosi, spi_miso, data_valid;
  logic [W-1:0] data_out;
`ifdef SPI_SLAVE_RX_ABORT_FLAG_EN
  logic         frame_abort;
  int           aborts = 0;
`endif
  int           checks = 0, errors = 0;
  logic [W-1:0] exp_q[$];
  logic         prev_valid = 1'b0;

  spi_slave_rx #(.IDLE_VAL(1'b1), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .data_out(data_out), .data_valid(data_valid)
`ifdef SPI_SLAVE_RX_ABORT_FLAG_EN
    , .frame_abort(frame_abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    spi_cs_n = 1'b0;
    spi_mosi = b;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    exp_q.push_back(w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  // gap bit carries the inverse of the last bit so a sampled gap would corrupt data
  task automatic gap();
    send_bit(~spi_mosi);
  endtask

  task automatic deselect(input logic b);
    @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = b;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        chk("valid_width", {31'b0, prev_valid}, 0);
        if (exp_q.size() == 0) chk("unexpected_valid", {24'b0, data_out}, 32'hFFFF_FFFF);
        else chk("data_out", {24'b0, data_out}, {24'b0, exp_q.pop_front()});
      end
`ifdef SPI_SLAVE_RX_ABORT_FLAG_EN
      if (frame_abort) begin
        aborts++;
        chk("abort_vs_valid", {31'b0, data_valid}, 0);
      end
`endif
    end
    prev_valid = data_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    #1;
    chk("rst_data_out", {24'b0, data_out}, 0);
    chk("rst_valid", {31'b0, data_valid}, 0);
    chk("rst_miso", {31'b0, spi_miso}, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) begin
      deselect(1'b1);
      chk("idle_data_out", {24'b0, data_out}, 0);
      chk("idle_valid", {31'b0, data_valid}, 0);
      chk("idle_miso", {31'b0, spi_miso}, 1);
    end
    send_word(8'h12);
    gap();
    chk("valid_after_last_bit_12", {31'b0, data_valid}, 1);
    send_word(8'h7E);
    gap();
    chk("valid_after_last_bit_7e", {31'b0, data_valid}, 1);
    chk("data_7e", {24'b0, data_out}, 32'h7E);
    deselect(1'b0);
    for (int i = 7; i >= 4; i--) send_bit(i == 5 || i == 4);
    deselect(1'b0);
    @(negedge clk);
`ifdef SPI_SLAVE_RX_ABORT_FLAG_EN
    chk("abort_pulse", {31'b0, frame_abort}, 1);
`endif
    chk("abort_valid", {31'b0, data_valid}, 0);
    chk("abort_hold", {24'b0, data_out}, 32'h7E);
    for (int i = 8; i >= 0; i--) deselect(i == 0 ? 1'b1 : ((8'hA5 >> (i - 1)) & 8'h01) != 0);
    @(negedge clk);
    chk("desel_hold", {24'b0, data_out}, 32'h7E);
    chk("desel_valid", {31'b0, data_valid}, 0);
    repeat (3) send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data_out", {24'b0, data_out}, 0);
    chk("arst_valid", {31'b0, data_valid}, 0);
    chk("arst_miso", {31'b0, spi_miso}, 1);
    spi_cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    send_word(8'h81);
    gap();
    chk("valid_after_last_bit_81", {31'b0, data_valid}, 1);
    deselect(1'b0);
    repeat (3) @(negedge clk);
    chk("final_data", {24'b0, data_out}, 32'h81);
    chk("scoreboard_empty", exp_q.size(), 0);
`ifdef SPI_SLAVE_RX_ABORT_FLAG_EN
    chk("abort_count", aborts, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
